// File: rtl/ps2_key_rx.sv
// ps2_key_rx - PS/2 keyboard receiver and make/break decoder.
//
// Receives 11-bit PS/2 frames, queues valid scan bytes in a small FIFO and
// decodes make/break (optionally E0-prefixed) sequences into a held-key code.
//
// Ports:
//   clk        system clock (>= 8x ps2_clk)
//   rst_n      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   key_code   held key scan code, 8'hFF when no key is held
//   press_cnt  count of new key presses (wraps)
//   key_ext    held key was E0-prefixed
//   key_valid  one-cycle pulse when key_code/key_ext change
//   frame_err  one-cycle pulse on bad start/stop/parity or timeout abort
//   overflow   sticky, a valid byte was dropped on a full FIFO
//
// Decoder states:
//   state     | meaning
//   S_IDLE    | waiting for a make code or a prefix
//   S_EXT     | E0 seen, next byte is an extended make or F0
//   S_BRK     | F0 seen, next byte is a normal break code
//   S_EXT_BRK | E0 F0 seen, next byte is an extended break code
module ps2_key_rx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic [7:0] press_cnt,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    // ---------------------------------------------------------------
    // Synchronizers and falling-edge detect
    // ---------------------------------------------------------------
    logic [2:0] clk_sync_q, dat_sync_q;
    logic       fall, din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 3'b111;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[1:0], ps2_data};
        end
    end

    assign fall = (clk_sync_q[2:1] == 2'b10);
    // Data taken from the stage holding the last pre-edge sample, where the
    // line is guaranteed stable.
    assign din  = dat_sync_q[2];

    // ---------------------------------------------------------------
    // Frame receiver
    // ---------------------------------------------------------------
    logic [3:0]  bit_cnt_q;
    logic [9:0]  shift_q;
    logic [15:0] tmo_q;
    logic        push_q;
    logic [7:0]  push_data_q;
    logic        frame_err_q;
    logic        frame_ok;

    // shift_q[0] = start, [8:1] = d0..d7, [9] = parity; din is the stop bit.
    assign frame_ok = !shift_q[0] && din && (^shift_q[9:1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= 4'd0;
            shift_q     <= 10'd0;
            tmo_q       <= 16'd0;
            push_q      <= 1'b0;
            push_data_q <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall) begin
                tmo_q <= 16'd0;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= 4'd0;
                    if (frame_ok) begin
                        push_q      <= 1'b1;
                        push_data_q <= shift_q[8:1];
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    shift_q   <= {din, shift_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (tmo_q == TIMEOUT - 16'd1) begin
                    bit_cnt_q   <= 4'd0;
                    tmo_q       <= 16'd0;
                    frame_err_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 16'd1;
                end
            end else begin
                tmo_q <= 16'd0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Scan-byte FIFO (pointers carry an extra wrap bit)
    // ---------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        empty, full, pop, do_push;
    logic        overflow_q;
    logic [7:0]  rd_data;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_q && (!full || pop);
    assign rd_data = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            if (pop)     rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            if (push_q && !do_push) overflow_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Make/break decoder
    // ---------------------------------------------------------------
    state_t     state_q;
    logic [7:0] key_code_q, press_cnt_q;
    logic       key_ext_q, key_valid_q;
    logic       is_make, is_brk, ext_sel;

    always_comb begin
        is_make = 1'b0;
        is_brk  = 1'b0;
        ext_sel = 1'b0;
        if (pop) begin
            case (state_q)
                S_IDLE:    is_make = (rd_data != 8'hE0) && (rd_data != 8'hF0);
                S_EXT: begin
                    is_make = (rd_data != 8'hF0);
                    ext_sel = 1'b1;
                end
                S_BRK:     is_brk = 1'b1;
                S_EXT_BRK: begin
                    is_brk  = 1'b1;
                    ext_sel = 1'b1;
                end
                default: ;
            endcase
        end
        // 8'hFF from the keyboard is its error code, never a key.
        if (rd_data == 8'hFF) is_make = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_code_q  <= 8'hFF;
            press_cnt_q <= 8'd0;
            key_ext_q   <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (pop) begin
                case (state_q)
                    S_IDLE: begin
                        if (rd_data == 8'hE0)      state_q <= S_EXT;
                        else if (rd_data == 8'hF0) state_q <= S_BRK;
                        else                       state_q <= S_IDLE;
                    end
                    S_EXT:   state_q <= (rd_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                    default: state_q <= S_IDLE;
                endcase

                if (is_make) begin
                    if (key_code_q == 8'hFF) press_cnt_q <= press_cnt_q + 8'd1;
                    if (rd_data != key_code_q || ext_sel != key_ext_q) begin
                        key_code_q  <= rd_data;
                        key_ext_q   <= ext_sel;
                        key_valid_q <= 1'b1;
                    end
                end

                if (is_brk && rd_data == key_code_q && ext_sel == key_ext_q) begin
                    key_code_q  <= 8'hFF;
                    key_ext_q   <= 1'b0;
                    key_valid_q <= 1'b1;
                end
            end
        end
    end

    assign key_code  = key_code_q;
    assign press_cnt = press_cnt_q;
    assign key_ext   = key_ext_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic [7:0] press_cnt;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;
    logic       overflow;

    ps2_key_rx #(
        .FIFO_DEPTH(8),
        .TIMEOUT   (16'd100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .press_cnt(press_cnt),
        .key_ext  (key_ext),
        .key_valid(key_valid),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         kv_cnt   = 0;
    int         err_cnt  = 0;
    logic [7:0] kv_log[$];

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            kv_log.push_back(key_code);
        end
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(4);
        ps2_clk = 1'b0;
        wait_clks(4);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of an 11-bit frame, then idles the lines.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        wait_clks(8);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic press_release(input logic [7:0] b);
        send(b);
        send(8'hF0);
        send(b);
    endtask

    int         kv0, err0, base;
    logic [7:0] got8, code;

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(5);

        // Reset state
        check("rst_key_code", key_code, 8'hFF);
        check("rst_press_cnt", press_cnt, 8'h00);
        check("rst_key_ext", key_ext, 1'b0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // 1C make with latency bound, then F0 1C break
        kv0 = kv_cnt;
        send_frame(8'h1C, 1'b0, 10);
        ps2_clk = 1'b0;              // stop-bit falling edge
        wait_clks(6);
        check("lat_key_code", key_code, 8'h1C);
        wait_clks(2);
        ps2_clk = 1'b1;
        wait_clks(8);
        check("make_kv", kv_cnt - kv0, 1);
        check("make_press", press_cnt, 8'd1);
        send(8'hF0);
        send(8'h1C);
        check("brk_key_code", key_code, 8'hFF);
        check("brk_kv", kv_cnt - kv0, 2);

        // Typematic repeat
        kv0 = kv_cnt;
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("rep_key_code", key_code, 8'h1C);
        send(8'hF0); send(8'h1C);
        check("rep_press", press_cnt, 8'd2);
        check("rep_kv", kv_cnt - kv0, 2);

        // Extended key
        send(8'hE0); send(8'h75);
        check("ext_key_code", key_code, 8'h75);
        check("ext_key_ext", key_ext, 1'b1);
        send(8'hF0); send(8'h75);
        check("ext_nobrk_code", key_code, 8'h75);
        check("ext_nobrk_ext", key_ext, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_brk_code", key_code, 8'hFF);
        check("ext_brk_ext", key_ext, 1'b0);
        check("ext_press", press_cnt, 8'd3);

        // Parity error
        err0 = err_cnt;
        send_frame(8'h1C, 1'b1, 11);
        check("par_err", err_cnt - err0, 1);
        check("par_key_code", key_code, 8'hFF);

        // Timeout abort, then a good frame
        err0 = err_cnt;
        send_frame(8'h00, 1'b0, 5);
        wait_clks(150);
        check("tmo_err", err_cnt - err0, 1);
        send(8'h32);
        check("tmo_next_code", key_code, 8'h32);
        check("tmo_err_once", err_cnt - err0, 1);
        send(8'hF0); send(8'h32);
        check("tmo_rel_code", key_code, 8'hFF);

        // Overflow with stalled decoder
        force dut.pop = 1'b0;
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
        check("ovf_flag", overflow, 1'b1);
        check("ovf_stall_code", key_code, 8'hFF);
        base = kv_log.size();
        release dut.pop;
        wait_clks(20);
        check("ovf_kv", kv_log.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            got8 = (base + i < kv_log.size()) ? kv_log[base + i] : 8'h00;
            check("ovf_order", got8, 8'h15 + 8'(i));
        end
        check("ovf_press", press_cnt, 8'd5);
        check("ovf_sticky", overflow, 1'b1);
        send(8'hF0); send(8'h1C);
        check("ovf_rel_code", key_code, 8'hFF);

        // Reset mid-frame
        send_frame(8'h00, 1'b0, 5);
        rst_n = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_press", press_cnt, 8'd0);
        err0 = err_cnt;
        send(8'h2A);
        check("mid_rst_code", key_code, 8'h2A);
        check("mid_rst_noerr", err_cnt - err0, 0);
        send(8'hF0); send(8'h2A);

        // press_cnt wrap (one press already counted since reset)
        for (int i = 0; i < 254; i++) begin
            code = 8'h01 + 8'(i % 100);
            press_release(code);
        end
        check("wrap_ff", press_cnt, 8'hFF);
        press_release(8'h3B);
        check("wrap_00", press_cnt, 8'h00);
        check("wrap_code", key_code, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
